// File: rtl/core_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative RV32M multiply/divide unit.
interface core_muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_dout;
    logic [XLEN-1:0] rs2_dout;
    logic            flush;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1_dout, rs2_dout, flush,
        input  busy, valid, result
    );

    modport slave (
        input  start, funct3, rs1_dout, rs2_dout, flush,
        output busy, valid, result
    );
endinterface

// File: rtl/core_muldiv_unit.sv
// Iterative RV32M sequencer: radix-2 shift-add multiply and restoring divide, one bit per cycle,
// with a single-cycle fast path for divide-by-zero and signed overflow.
module core_muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic               clk,
    input logic               rst_n,
    core_muldiv_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     opa_q, opa_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     quo_q, quo_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                accept, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]     abs_a, abs_b, fast_res;
    logic [XLEN:0]       mul_sum, rem_shift;
    logic [2*XLEN-1:0]   acc_step, prod_fix;
    logic                sub_ok;
    logic [XLEN-1:0]     rem_sub, rem_step, quo_step, quo_fix, rem_fix;
    logic [XLEN-1:0]     mul_res, div_res, calc_res;

    assign accept   = (state_q == StIdle) && bus.start && !bus.flush;
    assign a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b110);
    assign a_neg    = a_signed && bus.rs1_dout[XLEN-1];
    assign b_neg    = b_signed && bus.rs2_dout[XLEN-1];
    assign abs_a    = a_neg ? -bus.rs1_dout : bus.rs1_dout;
    assign abs_b    = b_neg ? -bus.rs2_dout : bus.rs2_dout;
    assign div_zero = bus.funct3[2] && (bus.rs2_dout == '0);
    assign div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                      (bus.rs1_dout == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_dout == '1);
    // funct3[1] selects REM/REMU over DIV/DIVU
    assign fast_res = div_zero ? (bus.funct3[1] ? bus.rs1_dout : '1)
                               : (bus.funct3[1] ? '0 : bus.rs1_dout);

    // Multiply: low half of acc holds the multiplier, shifted out LSB first.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    assign acc_step = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: the quotient register doubles as the dividend shift source.
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign sub_ok    = rem_shift >= {1'b0, opb_q};
    assign rem_sub   = rem_shift[XLEN-1:0] - opb_q;
    assign rem_step  = sub_ok ? rem_sub : rem_shift[XLEN-1:0];
    assign quo_step  = {quo_q[XLEN-2:0], sub_ok};

    assign prod_fix = neg_q ? -acc_step : acc_step;
    assign mul_res  = (funct3_q == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    assign quo_fix  = neg_q ? -quo_step : quo_step;
    assign rem_fix  = neg_q ? -rem_step : rem_step;
    assign div_res  = funct3_q[1] ? rem_fix : quo_fix;
    assign calc_res = funct3_q[2] ? div_res : mul_res;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        neg_d    = neg_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    funct3_d = bus.funct3;
                    unique case (bus.funct3)
                        3'b001, 3'b100: neg_d = a_neg ^ b_neg;
                        3'b010, 3'b110: neg_d = a_neg;
                        default:        neg_d = 1'b0;
                    endcase
                    opa_d = abs_a;
                    opb_d = abs_b;
                    acc_d = {{XLEN{1'b0}}, abs_b};
                    quo_d = abs_a;
                    rem_d = '0;
                    if (div_zero || div_ovf) begin
                        state_d  = StDone;
                        cnt_d    = '0;
                        result_d = fast_res;
                    end else begin
                        state_d = StCalc;
                        cnt_d   = CntW'(XLEN);
                    end
                end
            end
            StCalc: begin
                if (bus.flush) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    acc_d = acc_step;
                    quo_d = quo_step;
                    rem_d = rem_step;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d  = StDone;
                        result_d = calc_res;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = accept || (state_q == StCalc);
    assign bus.valid  = (state_q == StDone) && !bus.flush;
    assign bus.result = result_q;
endmodule

// File: tb/tb_core_muldiv_unit.sv
// Self-checking bench for core_muldiv_unit: scoreboarded directed and random M-extension ops,
// fast paths, flushes and mid-op reset.
module tb_core_muldiv_unit;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_muldiv_unit_if #(.XLEN(XLEN)) bus ();

    core_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_result = '0;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b);
        if (f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Issues one op, holds start until the completion pulse, then scoreboards the result.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input string name, input bit no_wait);
        int          lat, seen_at;
        bit          busy_ok, seen;
        logic [31:0] got, expd;
        lat = lat_of(f, a, b);
        if (!no_wait) begin
            @(posedge clk);
            #1;
        end
        bus.start    = 1'b1;
        bus.funct3   = f;
        bus.rs1_dout = a;
        bus.rs2_dout = b;
        exp_q.push_back(expv);
        busy_ok = 1'b1;
        seen    = 1'b0;
        seen_at = 0;
        #1;
        if (bus.busy !== 1'b1 || bus.valid !== 1'b0) busy_ok = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus.valid === 1'b1) begin
                seen    = 1'b1;
                seen_at = k;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
                got  = bus.result;
                expd = exp_q.pop_front();
                bus.start = 1'b0;
                last_result = expd;
                n_checks++;
                if (got !== expd) begin
                    n_fail++;
                    $display("FAIL %s result: got %h expected %h", name, got, expd);
                end
            end else if (bus.busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s timeout: no valid within 40 cycles", name);
            bus.start = 1'b0;
            void'(exp_q.pop_front());
        end else if (seen_at != lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, seen_at, lat);
        end
        n_checks++;
        if (!busy_ok) begin
            n_fail++;
            $display("FAIL %s busy_window: busy/valid wrong before completion got 0 expected 1",
                     name);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
        n_checks++;
        if (bus.valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.valid);
        end
        n_checks++;
        if (bus.result !== 32'h0) begin
            n_fail++; $display("FAIL reset_result: got %h expected 0", bus.result);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_mul;
        run_op(3'b000, 32'd7, 32'd6, 32'd42, "mul_7x6", 1'b0);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh", 1'b0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "mulhsu", 1'b0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu", 1'b0);
    endtask

    task automatic test_div;
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_neg", 1'b0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_neg", 1'b0);
        run_op(3'b101, 32'd100, 32'd7, 32'd14, "divu", 1'b0);
        run_op(3'b111, 32'd100, 32'd7, 32'd2, "remu", 1'b0);
    endtask

    task automatic test_fast_path;
        run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by_zero", 1'b0);
        run_op(3'b110, 32'd5, 32'd0, 32'd5, "rem_by_zero", 1'b0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf", 1'b0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf", 1'b0);
    endtask

    task automatic test_flush;
        // Flush during CALC
        @(posedge clk);
        #1;
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.rs1_dout = 32'd1000; bus.rs2_dout = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL flush_calc_busy_before: got %b expected 1", bus.busy);
        end
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_calc_idle: got busy %b valid %b expected 0 0", bus.busy, bus.valid);
        end
        n_checks++;
        if (bus.result !== last_result) begin
            n_fail++;
            $display("FAIL flush_calc_result: got %h expected %h", bus.result, last_result);
        end
        run_op(3'b100, 32'd1000, 32'd3, 32'd333, "after_flush", 1'b1);

        // Flush and start together in IDLE: no acceptance
        @(posedge clk);
        #1;
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b000;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_beats_start: got busy %b expected 0", bus.busy);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_beats_start_idle: got busy %b valid %b expected 0 0",
                     bus.busy, bus.valid);
        end

        // Flush in DONE suppresses the pulse
        @(posedge clk);
        #1;
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.rs1_dout = 32'd5; bus.rs2_dout = 32'd5;
        repeat (33) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.start = 1'b0;
        #1;
        n_checks++;
        if (bus.valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_done_valid: got %b expected 0", bus.valid);
        end
        last_result = 32'd25;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_done_idle: got busy %b valid %b expected 0 0", bus.busy, bus.valid);
        end
    endtask

    task automatic test_back_to_back;
        run_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, model(3'b011, 32'h1234_5678, 32'h9ABC_DEF0),
               "b2b_first", 1'b0);
        @(posedge clk);
        #1;
        run_op(3'b111, 32'hDEAD_BEEF, 32'h0000_1234, model(3'b111, 32'hDEAD_BEEF, 32'h0000_1234),
               "b2b_second", 1'b1);
    endtask

    task automatic test_reset_midop;
        @(posedge clk);
        #1;
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.rs1_dout = 32'd1234; bus.rs2_dout = 32'd5678;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.start = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.result !== 32'h0) begin
            n_fail++;
            $display("FAIL midop_reset: got busy %b valid %b result %h expected 0 0 0",
                     bus.busy, bus.valid, bus.result);
        end
        last_result = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(3'b000, 32'd3, 32'd3, 32'd9, "mul_after_reset", 1'b0);
    endtask

    task automatic test_random;
        logic [2:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                default: b = 32'($urandom);
            endcase
            run_op(f, a, b, model(f, a, b), "random", 1'b0);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.funct3   = '0;
        bus.rs1_dout = '0;
        bus.rs2_dout = '0;
        bus.flush    = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_flush();
        test_back_to_back();
        test_reset_midop();
        test_random();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
